key_collector: RTL and testbench
================================

Name: key_collector

Overview:
- Downstream of the parallel brute-force workers. Consumes the per-worker "found" flag and 128-bit key outputs of TOTAL search instances.
- Arbitrates the first hit and latches the winning key, worker index and search duration.
- Streams an 18-byte result frame over a byte-wide valid/ready interface to the host link (UART/FIFO).

Parameters:
- TOTAL, 4, number of worker instances feeding the block (>=1).
- IDX_W, 2, width of winner index; must satisfy 2^IDX_W >= TOTAL and IDX_W <= 8.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle arm pulse; begins a search window.
- found  in  TOTAL  per-worker hit flag; bit i from worker i, level, may stay high.
- keys  in  128*TOTAL  per-worker key; worker i at [128*i+127 : 128*i].
- busy  out  1  high in SEARCH and SEND.
- done  out  1  high in DONE.
- winner  out  IDX_W  index of winning worker.
- key  out  128  latched winning key.
- cycles  out  32  SEARCH cycles elapsed before the hit.
- tx_data  out  8  frame byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts byte when high with tx_valid.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state IDLE; busy=0, done=0, winner=0, key=0, cycles=0, tx_data=0, tx_valid=0;
  - byte counter = 0.
  - Applies immediately mid-frame: tx_valid drops without completing the frame.
- All outputs are registered. No combinational path from found/keys/tx_ready to any output.
- FSM states IDLE, SEARCH, SEND, DONE:
  - IDLE:
    - found ignored.
    - start=1 -> SEARCH next edge; clears cycles, key, winner.
  - SEARCH, each edge:
    - If found != 0: lowest set index i wins. key <= keys slice i; winner <= i; cycles holds; byte counter <= 0; -> SEND.
    - Else cycles <= cycles+1, saturating at 32'hFFFFFFFF (no wrap). Stays in SEARCH indefinitely.
    - Hit on the first SEARCH edge gives cycles=0.
    - start ignored.
  - SEND:
    - tx_valid=1 and tx_data = frame[byte counter].
    - On an edge with tx_valid && tx_ready: counter+1.
    - tx_data and tx_valid held stable while tx_ready=0.
    - After byte 17 is accepted: tx_valid <= 0 -> DONE.
    - start and found ignored.
  - DONE:
    - done=1; key, winner and cycles held.
    - start=1 -> SEARCH; clears done, cycles, key, winner.
- Frame (18 bytes):
  - byte0 = 8'hA5 (sync);
  - byte1 = winner zero-extended to 8 bits;
  - bytes 2..17 = key MSB first: byte k = key[127-8*(k-2) -: 8].
- Throughput: with tx_ready held 1, the frame occupies exactly 18 consecutive cycles of tx_valid=1.
- Simultaneous events:
  - start and found together in IDLE/DONE: only start acts; found is first sampled on the next edge, in SEARCH.
  - Multiple found bits on the same edge: lowest index wins, others discarded.
  - found rising on the last-byte handshake edge is ignored.
- busy = (state==SEARCH || state==SEND); done = (state==DONE); both registered alongside the state.

Test Plan:
1. Reset mid-SEND at byte 5 with tx_ready=1 -> tx_valid=0 asynchronously; all outputs 0; state IDLE; next start restarts cleanly with cycles=0.
2. TOTAL=4. start, then found=4'b0000 for 10 edges, then found=4'b0100 with keys slice 2 = 128'h0123456789ABCDEF_FEDCBA9876543210.
   - Expect winner=2, cycles=10, busy=1.
   - With tx_ready=1, tx_data sequence A5,02,01,23,45,67,89,AB,CD,EF,FE,DC,BA,98,76,54,32,10 on 18 consecutive cycles, then done=1, busy=0.
3. found=4'b1010 on the first SEARCH edge -> winner=1, cycles=0, key = slice 1.
4. Backpressure: tx_ready toggles 1,0,0,1,... -> each byte held stable while tx_ready=0; no byte is skipped or duplicated; 18 handshakes in total.
5. found=4'b0001 held high in IDLE with no start for 20 cycles -> state stays IDLE, tx_valid=0. In DONE, start plus found=4'b1000 on the same edge -> SEARCH; the next edge latches winner=3.
6. Saturation: force cycles to 32'hFFFFFFFD in SEARCH, keep found=0 for 5 edges -> cycles reads FFFFFFFE, FFFFFFFF, FFFFFFFF, ... with no wrap to 0.

Source files
------------

// File: rtl/key_collector.sv
// key_collector: arbitrates the first worker hit, latches key/index/duration and streams an 18-byte result frame
// Ports:
//   clk, rst (async active-low)  - clock and reset
//   start                        - single-cycle arm pulse, opens a search window
//   found[TOTAL], keys[128*TOTAL]- per-worker hit flags and keys
//   busy, done                   - status (SEARCH/SEND, DONE)
//   winner, key, cycles          - latched result
//   tx_data, tx_valid, tx_ready  - byte-wide frame stream: A5, winner, key MSB first
module key_collector #(
  parameter int TOTAL = 4,
  parameter int IDX_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [TOTAL-1:0]       found,
  input  logic [128*TOTAL-1:0]   keys,
  output logic                   busy,
  output logic                   done,
  output logic [IDX_W-1:0]       winner,
  output logic [127:0]           key,
  output logic [31:0]            cycles,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready
);
  typedef enum logic [1:0] {IDLE, SEARCH, SEND, DONE} state_t;
  state_t state;
  logic [4:0] cnt;
  logic [4:0] nxt;
  logic [3:0] kb;
  logic [IDX_W-1:0] hit;
  logic [127:0] hit_key;
  logic [7:0] nxt_byte;
  // descending scan so the lowest set index is the last (winning) assignment
  always_comb begin
    hit = '0;
    hit_key = '0;
    for (int i = TOTAL-1; i >= 0; i--)
      if (found[i]) begin
        hit = IDX_W'(i);
        hit_key = keys[128*i +: 128];
      end
    nxt = cnt + 5'd1;
    kb = 4'(5'd17 - nxt);
    nxt_byte = (nxt == 5'd1) ? 8'(winner) : key[{kb, 3'b000} +: 8];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      winner <= '0;
      key <= '0;
      cycles <= '0;
      tx_data <= '0;
      tx_valid <= 1'b0;
      cnt <= '0;
    end else
      case (state)
        IDLE, DONE:
          if (start) begin
            state <= SEARCH;
            busy <= 1'b1;
            done <= 1'b0;
            cycles <= '0;
            key <= '0;
            winner <= '0;
          end
        SEARCH:
          if (|found) begin
            state <= SEND;
            key <= hit_key;
            winner <= hit;
            cnt <= '0;
            tx_data <= 8'hA5;
            tx_valid <= 1'b1;
          end else if (cycles != '1)
            cycles <= cycles + 32'd1;
        default:
          if (tx_ready) begin
            if (cnt == 5'd17) begin
              state <= DONE;
              busy <= 1'b0;
              done <= 1'b1;
              tx_valid <= 1'b0;
              tx_data <= '0;
            end else begin
              cnt <= nxt;
              tx_data <= nxt_byte;
            end
          end
      endcase
endmodule

// File: tb/tb_key_collector.sv
// tb_key_collector: directed self-checking bench for key_collector
module tb_key_collector;
  localparam int TOTAL = 4;
  localparam int IDX_W = 2;
  localparam logic [127:0] K0 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] K1 = 128'hC0FFEE00DEADBEEF1357924680ACE135;
  localparam logic [127:0] K2 = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] K3 = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, tx_ready = 1'b0;
  logic [TOTAL-1:0] found = '0;
  logic [128*TOTAL-1:0] keys = '0;
  logic busy, done, tx_valid;
  logic [IDX_W-1:0] winner;
  logic [127:0] key;
  logic [31:0] cycles;
  logic [7:0] tx_data;
  int vecs = 0, miss = 0;
  logic [7:0] exp2 [18] = '{8'hA5, 8'h02, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD,
                            8'hEF, 8'hFE, 8'hDC, 8'hBA, 8'h98, 8'h76, 8'h54, 8'h32, 8'h10};

  key_collector #(.TOTAL(TOTAL), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .found(found), .keys(keys),
    .busy(busy), .done(done), .winner(winner), .key(key), .cycles(cycles),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  function automatic logic [7:0] fb(input logic [7:0] w, input logic [127:0] k, input int n);
    logic [127:0] s;
    s = k << (8 * (n - 2));
    return n == 0 ? 8'hA5 : n == 1 ? w : s[127:120];
  endfunction

  task automatic drain(input string tag, input logic [7:0] w, input logic [127:0] k);
    for (int n = 0; n < 18; n++) begin
      chk({tag, "_valid"}, 128'(tx_valid), 128'(1));
      chk({tag, "_byte"}, 128'(tx_data), 128'(fb(w, k, n)));
      step();
    end
    chk({tag, "_done"}, 128'(done), 128'(1));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_valid_end"}, 128'(tx_valid), 128'(0));
  endtask

  initial begin
    int idx, cyc;
    keys = {K3, K2, K1, K0};
    #2;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_valid", 128'(tx_valid), 128'(0));
    chk("rst_all", {winner, key[63:0], cycles, tx_data}, '0);
    step();
    rst = 1'b1;
    tx_ready = 1'b1;
    // basic search: 10 idle edges then worker 2 hits
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    chk("t2_cycles_search", 128'(cycles), 128'(10));
    found = 4'b0100;
    step();
    found = '0;
    chk("t2_winner", 128'(winner), 128'(2));
    chk("t2_cycles", 128'(cycles), 128'(10));
    chk("t2_busy", 128'(busy), 128'(1));
    chk("t2_key", key, K2);
    for (int n = 0; n < 18; n++) begin
      chk("t2_valid", 128'(tx_valid), 128'(1));
      chk("t2_byte", 128'(tx_data), 128'(exp2[n]));
      step();
    end
    chk("t2_done", 128'(done), 128'(1));
    chk("t2_busy_end", 128'(busy), 128'(0));
    // hit on first SEARCH edge with two bits set, then backpressured frame
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t3_done_clear", 128'(done), 128'(0));
    found = 4'b1010;
    step();
    found = '0;
    chk("t3_winner", 128'(winner), 128'(1));
    chk("t3_cycles", 128'(cycles), 128'(0));
    chk("t3_key", key, K1);
    idx = 0;
    cyc = 0;
    while (idx < 18 && cyc < 100) begin
      chk("t4_valid", 128'(tx_valid), 128'(1));
      chk("t4_byte", 128'(tx_data), 128'(fb(8'd1, K1, idx)));
      tx_ready = (cyc % 3 == 0);
      step();
      if (tx_ready) idx++;
      cyc++;
    end
    chk("t4_handshakes", 128'(idx), 128'(18));
    chk("t4_cycles_used", 128'(cyc), 128'(52));
    chk("t4_done", 128'(done), 128'(1));
    tx_ready = 1'b1;
    // asynchronous reset in the middle of the frame
    start = 1'b1;
    step();
    start = 1'b0;
    found = 4'b0001;
    step();
    found = '0;
    repeat (5) step();
    chk("t1_byte5", 128'(tx_data), 128'(fb(8'd0, K0, 5)));
    #2 rst = 1'b0;
    #1;
    chk("t1_valid", 128'(tx_valid), 128'(0));
    chk("t1_busy", 128'(busy), 128'(0));
    chk("t1_outs", {winner, key[63:0], cycles, tx_data}, '0);
    chk("t1_key", key, '0);
    step();
    rst = 1'b1;
    // found held high in IDLE is ignored
    found = 4'b0001;
    cyc = 0;
    repeat (20) begin
      step();
      if (tx_valid !== 1'b0 || busy !== 1'b0) cyc++;
    end
    chk("t5_idle_quiet", 128'(cyc), 128'(0));
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_restart_cycles", 128'(cycles), 128'(0));
    chk("t1_restart_valid", 128'(tx_valid), 128'(0));
    step();
    found = '0;
    chk("t1_restart_winner", 128'(winner), 128'(0));
    chk("t1_restart_cyc0", 128'(cycles), 128'(0));
    drain("t1_frame", 8'd0, K0);
    // start and found together in DONE: only start acts
    start = 1'b1;
    found = 4'b1000;
    step();
    start = 1'b0;
    chk("t5_search_busy", 128'(busy), 128'(1));
    chk("t5_search_valid", 128'(tx_valid), 128'(0));
    chk("t5_search_cycles", 128'(cycles), 128'(0));
    step();
    found = '0;
    chk("t5_winner", 128'(winner), 128'(3));
    chk("t5_key", key, K3);
    drain("t5_frame", 8'd3, K3);
    // cycle counter saturation
    start = 1'b1;
    step();
    start = 1'b0;
    force dut.cycles = 32'hFFFFFFFD;
    #1 release dut.cycles;
    chk("t6_forced", 128'(cycles), 128'(32'hFFFFFFFD));
    step();
    chk("t6_fe", 128'(cycles), 128'(32'hFFFFFFFE));
    step();
    chk("t6_ff", 128'(cycles), 128'(32'hFFFFFFFF));
    repeat (3) begin
      step();
      chk("t6_sat", 128'(cycles), 128'(32'hFFFFFFFF));
    end
    chk("t6_busy", 128'(busy), 128'(1));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
